// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the datapath adder chain.
//   ADDER_WIDTH    : default operand / sum width in bits (16)
//   adder_result_t : combined {carry, sum} value, ADDER_WIDTH+1 bits, so the
//                    carry-out and sum can be handled as one unsigned number
// -----------------------------------------------------------------------------
package adder_pkg;

  localparam int ADDER_WIDTH = 16;

  typedef logic [ADDER_WIDTH:0] adder_result_t;

endpackage : adder_pkg

// File: rtl/full_adder_1bit.sv
// -----------------------------------------------------------------------------
// full_adder_1bit
// Purely combinational 1-bit full adder; one link of the ripple-carry chain.
// Ports:
//   a, b  : operand bits
//   c_in  : carry into this bit
//   sum   : a ^ b ^ c_in
//   c_out : carry out of this bit
// -----------------------------------------------------------------------------
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  logic w_prop;

  // Propagate term is shared between the sum and the carry expressions.
  assign w_prop = a ^ b;
  assign sum    = w_prop ^ c_in;
  assign c_out  = (a & b) | (c_in & w_prop);

endmodule : full_adder_1bit

// File: rtl/full_adder_16bit.sv
// -----------------------------------------------------------------------------
// full_adder_16bit
// Registered ripple-carry adder: {c_out, sum} = a + b + c_in, one cycle after
// the operands are presented. A new operation is accepted every cycle.
// Ports:
//   clk   : system clock, rising-edge active
//   rst   : asynchronous, active-high reset (clears all outputs)
//   a, b  : unsigned WIDTH-bit operands
//   c_in  : carry into bit 0
//   sum   : registered low WIDTH bits of the result
//   c_out : registered carry out of bit WIDTH-1
//   ovf   : registered two's-complement overflow flag (optional)
// Build option:
//   FULL_ADDER_16BIT_OVF_EN : when defined, adds the ovf port and its logic.
// -----------------------------------------------------------------------------
module full_adder_16bit
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
`ifdef FULL_ADDER_16BIT_OVF_EN
  output logic             c_out,
  output logic             ovf
`else
  output logic             c_out
`endif
);

  // w_carry[i] is the carry into bit i; w_carry[WIDTH] is the final carry out.
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;

  logic [WIDTH-1:0] r_sum;
  logic             r_c_out;

  assign w_carry[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_1bit u_fa (
      .a     (a[i]),
      .b     (b[i]),
      .c_in  (w_carry[i]),
      .sum   (w_sum[i]),
      .c_out (w_carry[i+1])
    );
  end : g_bit

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs, regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum   <= '0;
      r_c_out <= 1'b0;
    end else begin
      r_sum   <= w_sum;
      r_c_out <= w_carry[WIDTH];
    end
  end

  assign sum   = r_sum;
  assign c_out = r_c_out;

`ifdef FULL_ADDER_16BIT_OVF_EN
  logic w_ovf;
  logic r_ovf;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign w_ovf = w_carry[WIDTH] ^ w_carry[WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ovf <= 1'b0;
    else     r_ovf <= w_ovf;
  end

  assign ovf = r_ovf;
`endif

endmodule : full_adder_16bit

// File: tb/tb_full_adder_16bit.sv
// -----------------------------------------------------------------------------
// tb_full_adder_16bit
// Self-checking bench for full_adder_16bit. Operands are driven on the falling
// edge and the expected {ovf, c_out, sum} is pushed to a scoreboard queue; the
// entry is popped and compared on the next falling edge, i.e. one full cycle
// after the inputs were presented. Expected values come from plain integer
// arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_full_adder_16bit;
  import adder_pkg::*;

  localparam int W = ADDER_WIDTH;

  typedef struct {
    adder_result_t res;
    logic          ovf;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic [W-1:0] sum;
  logic         c_out;
`ifdef FULL_ADDER_16BIT_OVF_EN
  logic         ovf;
`endif

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  full_adder_16bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .sum   (sum),
`ifdef FULL_ADDER_16BIT_OVF_EN
    .c_out (c_out),
    .ovf   (ovf)
`else
    .c_out (c_out)
`endif
  );

  // Drive one operation and record what the DUT must show a cycle later.
  task automatic drive(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
    exp_t e;
    a    = va;
    b    = vb;
    c_in = vc;
    e.res = adder_result_t'(va) + adder_result_t'(vb) + adder_result_t'(vc);
    // Two's-complement overflow: equal operand signs, different result sign.
    e.ovf = (va[W-1] == vb[W-1]) && (e.res[W-1] != va[W-1]);
    e.a   = va;
    e.b   = vb;
    e.cin = vc;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    a    = '0;
    b    = '0;
    c_in = 1'b0;
    #1;
    checks++;
    if ({c_out, sum} !== adder_result_t'(0)) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", {c_out, sum}, adder_result_t'(0));
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_ones();
    logic [W-1:0] va[4] = '{16'h0000, 16'h0001, 16'h0000, 16'h0000};
    logic [W-1:0] vb[4] = '{16'h0000, 16'h0000, 16'h0001, 16'h0000};
    logic         vc[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    exp_t e;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({c_out, sum} !== e.res) begin
          errors++;
          $display("FAIL single_ones %h+%h+%0d: got %h expected %h", e.a, e.b, e.cin, {c_out, sum}, e.res);
        end
      end
      if (i < 4) drive(va[i], vb[i], vc[i]);
    end
  endtask

  task automatic test_carry_ripple();
    logic [W-1:0] va[5] = '{16'h0001, 16'h00FF, 16'h00FF, 16'h00F0, 16'h00FF};
    logic [W-1:0] vb[5] = '{16'h0001, 16'h0001, 16'h0000, 16'h00F0, 16'h00FF};
    logic         vc[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_t e;
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({c_out, sum} !== e.res) begin
          errors++;
          $display("FAIL carry_ripple %h+%h+%0d: got %h expected %h", e.a, e.b, e.cin, {c_out, sum}, e.res);
        end
      end
      if (i < 5) drive(va[i], vb[i], vc[i]);
    end
  endtask

  task automatic test_full_carry();
    exp_t e;
    for (int i = 0; i <= 2; i++) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({c_out, sum} !== e.res) begin
          errors++;
          $display("FAIL full_carry %h+%h+%0d: got %h expected %h", e.a, e.b, e.cin, {c_out, sum}, e.res);
        end
      end
      if (i < 2) drive(16'hFFFF, 16'hFFFF, i[0]);
    end
  endtask

  // Ten consecutive operations, one per cycle; each must surface exactly one
  // cycle after it was driven with no gaps.
  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({c_out, sum} !== e.res) begin
          errors++;
          $display("FAIL back_to_back[%0d] %h+%h+%0d: got %h expected %h", i, e.a, e.b, e.cin, {c_out, sum}, e.res);
        end
      end
      if (i < 10) drive(W'($urandom), W'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    @(negedge clk);
    drive(16'hFFFF, 16'hFFFF, 1'b1);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if ({c_out, sum} !== e.res) begin
      errors++;
      $display("FAIL pre_reset_result: got %h expected %h", {c_out, sum}, e.res);
    end
    // Assert reset between edges: outputs must clear without a clock edge.
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({c_out, sum} !== adder_result_t'(0)) begin
      errors++;
      $display("FAIL async_reset_assert: got %h expected %h", {c_out, sum}, adder_result_t'(0));
    end
    @(posedge clk);
    #1;
    checks++;
    if ({c_out, sum} !== adder_result_t'(0)) begin
      errors++;
      $display("FAIL reset_hold: got %h expected %h", {c_out, sum}, adder_result_t'(0));
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({c_out, sum} !== adder_result_t'(0)) begin
      errors++;
      $display("FAIL reset_release_no_edge: got %h expected %h", {c_out, sum}, adder_result_t'(0));
    end
    @(posedge clk);
    #1;
    checks++;
    if ({c_out, sum} !== adder_result_t'(17'h1FFFF)) begin
      errors++;
      $display("FAIL reset_release_first_edge: got %h expected %h", {c_out, sum}, adder_result_t'(17'h1FFFF));
    end
  endtask

`ifdef FULL_ADDER_16BIT_OVF_EN
  task automatic test_ovf();
    logic [W-1:0] va[4] = '{16'h7FFF, 16'hFFFF, 16'h8000, 16'h1234};
    logic [W-1:0] vb[4] = '{16'h0001, 16'h0001, 16'h8000, 16'h0001};
    exp_t e;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({ovf, c_out, sum} !== {e.ovf, e.res}) begin
          errors++;
          $display("FAIL ovf %h+%h+%0d: got ovf=%b res=%h expected ovf=%b res=%h", e.a, e.b, e.cin, ovf, {c_out, sum}, e.ovf, e.res);
        end
      end
      if (i < 4) drive(va[i], vb[i], 1'b0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_ones();
    test_carry_ripple();
    test_full_carry();
    test_back_to_back();
`ifdef FULL_ADDER_16BIT_OVF_EN
    test_ovf();
`endif
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_full_adder_16bit
